dual_port_dmem: RTL and testbench
=================================

DUAL_PORT_DMEM -- requirements
Module: dual_port_dmem

Interface
REQ-001 SHALL have parameter DATA_W, default 32, word width in bits; a multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 256, number of words.
REQ-003 SHALL have parameter RD_MODE, default 0, same-word read/write behaviour: 0 read-first, 1 write-first.
REQ-004 SHALL have parameter CLEAR_ON_RESET, default 1, meaning 1 zero-fills the array after reset.
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 Ports (name  direction  width  meaning):
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- we, te  in  1  write enable, CPU port / T port.
- re, tre  in  1  read enable, CPU port / T port.
- a, ta  in  32  byte address, CPU port / T port.
- wd, td  in  DATA_W  write data.
- be, tbe  in  DATA_W/8  byte-lane enables.
- rd, rtd  out  DATA_W  registered read data.
- rvalid, trvalid  out  1  read-data-valid pulse.
- aerr, terr  out  1  out-of-range pulse.
- ready  out  1  memory accepting accesses.

Function
REQ-007 SHALL form the word index as the address with its low log2(DATA_W/8) bits dropped; those low bits are ignored.
REQ-008 While ready=0, SHALL ignore all requests: no writes, no valid pulses, no error pulses.
REQ-009 Write: when ready=1, we=1 and index<DEPTH, SHALL update only the lanes with be[i]=1 at the clock edge; the T port behaves identically.
REQ-010 Read: when ready=1 and re=1, SHALL drive rd and assert rvalid exactly one cycle later, for one cycle; the T port behaves identically.
REQ-011 rd/rtd SHALL hold their last value when no read completes.
REQ-012 Index>=DEPTH: SHALL suppress the write, return 0 on a read, and pulse aerr/terr one cycle after the request; a read also asserts its valid.
REQ-013 Both ports write the same word in one cycle: CPU port wins on lanes enabled by both; lanes enabled only by tbe take td.
REQ-014 A read of a word written in the same cycle, by either port, SHALL return old data when RD_MODE=0, and the merged post-write data when RD_MODE=1.
REQ-015 Simultaneous reads of any words on both ports SHALL both complete with no stall.
REQ-016 Init FSM states are INIT and RUN.
REQ-017 INIT: writes zero to index 0..DEPTH-1, one word per cycle, with ready=0.
REQ-018 INIT moves to RUN on the cycle after index DEPTH-1 is written.
REQ-019 INIT duration SHALL be exactly DEPTH cycles after rst_n deasserts.
REQ-020 With CLEAR_ON_RESET=0, SHALL enter RUN directly, leaving array contents unchanged and undefined.
REQ-021 RUN SHALL have no exit except reset.

Reset
REQ-022 rst_n low SHALL immediately force rd=0, rtd=0, rvalid=0, trvalid=0, aerr=0, terr=0, ready=0, and the clear counter to 0.
REQ-023 The FSM SHALL enter INIT on reset, or RUN when CLEAR_ON_RESET=0.
REQ-024 Reset during INIT SHALL restart clearing from index 0.
REQ-025 Reset in RUN SHALL drop in-flight reads without a valid pulse.
REQ-026 The array itself SHALL NOT be reset asynchronously.

Structure
REQ-027 Package dmem_pkg SHALL hold the FSM state type, the RD_MODE constants (RD_FIRST=0, WR_FIRST=1), and a lane-count function.
REQ-028 Sub-module dmem_clear_seq SHALL own the INIT/RUN FSM and clear counter, outputting ready, the clear address and the clear write strobe.
REQ-029 The array SHALL be inferable as block RAM: behavioural, with no reset on storage.

Verification
REQ-030 Release rst_n; DEPTH=256 -> ready rises exactly 256 cycles later; reading index 0, 17 and 255 returns 0x00000000.
REQ-031 Write 0xDEADBEEF at a=0x40 with be=0xF, then re at a=0x40 -> rd=0xDEADBEEF with rvalid one cycle after re; the same read with a=0x43 returns the identical word.
REQ-032 Same word in one cycle: CPU writes 0x11111111 with be=0x3, T writes 0x22222222 with tbe=0x6 -> word reads 0x00221111 (lanes 0-1 from CPU, lane 2 from T, lane 3 keeps its cleared zero).
REQ-033 RD_MODE=0 vs 1: word holds 0xA5A5A5A5; we writes 0x5A5A5A5A while tre reads the same word -> rtd=0xA5A5A5A5 when RD_MODE=0, 0x5A5A5A5A when RD_MODE=1.
REQ-034 Out of range: read at a=0x400 (index 256, DEPTH=256) -> rd=0, rvalid=1, aerr=1 for one cycle; a write there leaves index 0 unchanged.
REQ-035 rst_n pulsed low at INIT index 100 -> outputs go to 0 immediately; ready rises 256 cycles after release.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the dual-port data memory.
//   state_e    : clear-sequencer states (INIT zero-fills, RUN serves accesses)
//   RD_FIRST / WR_FIRST : values for the RD_MODE parameter
//   lane_count : number of byte lanes in a data word
package dmem_pkg;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam int unsigned RD_FIRST = 0;
   localparam int unsigned WR_FIRST = 1;

   function automatic int unsigned lane_count(input int unsigned data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/dmem_clear_seq.sv
// Post-reset clear sequencer for dual_port_dmem.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   ready      : high once the array is usable (state RUN)
//   clr_addr   : word index being zeroed during INIT
//   clr_we     : strobe writing zero to clr_addr
module dmem_clear_seq
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH          = 256,
   parameter int unsigned CLEAR_ON_RESET = 1,
   localparam int unsigned AW            = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   output logic          ready,
   output logic [AW-1:0] clr_addr,
   output logic          clr_we
);

   state_e        state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic          ready_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= (CLEAR_ON_RESET != 0) ? INIT : RUN;
         cnt_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         // ready is registered so it is forced low by reset even when the
         // sequencer comes straight up in RUN.
         ready_q <= (state_d == RUN);
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      clr_we  = 1'b0;
      case (state_q)
         INIT: begin
            clr_we = 1'b1;
            if (cnt_q == AW'(DEPTH - 1)) begin
               state_d = RUN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RUN: begin
            state_d = RUN;
         end
         default: state_d = INIT;
      endcase
   end

   assign ready    = ready_q;
   assign clr_addr = cnt_q;

endmodule

// File: rtl/dual_port_dmem.sv
// Dual-port byte-enabled data memory (CPU port + T port), one clock.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   we/te, re/tre       : write / read enables (CPU / T)
//   a/ta                : byte addresses; low log2(DATA_W/8) bits ignored
//   wd/td, be/tbe       : write data and byte-lane enables
//   rd/rtd              : registered read data, held between reads
//   rvalid/trvalid      : read data valid pulse, one cycle after the request
//   aerr/terr           : out-of-range pulse, one cycle after the request
//   ready               : high when accesses are accepted
module dual_port_dmem
   import dmem_pkg::*;
#(
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned DEPTH          = 256,
   parameter int unsigned RD_MODE        = 0,
   parameter int unsigned CLEAR_ON_RESET = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic                  te,
   input  logic                  re,
   input  logic                  tre,
   input  logic [31:0]           a,
   input  logic [31:0]           ta,
   input  logic [DATA_W-1:0]     wd,
   input  logic [DATA_W-1:0]     td,
   input  logic [DATA_W/8-1:0]   be,
   input  logic [DATA_W/8-1:0]   tbe,
   output logic [DATA_W-1:0]     rd,
   output logic [DATA_W-1:0]     rtd,
   output logic                  rvalid,
   output logic                  trvalid,
   output logic                  aerr,
   output logic                  terr,
   output logic                  ready
);

   localparam int unsigned NB  = lane_count(DATA_W);
   localparam int unsigned OFS = (NB > 1) ? $clog2(NB) : 0;
   localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [AW-1:0] clr_addr;
   logic          clr_we;

   dmem_clear_seq #(
      .DEPTH          (DEPTH),
      .CLEAR_ON_RESET (CLEAR_ON_RESET)
   ) u_clear_seq (
      .clk      (clk),
      .rst_n    (rst_n),
      .ready    (ready),
      .clr_addr (clr_addr),
      .clr_we   (clr_we)
   );

   logic [31:0]   cidx, tidx;
   logic [AW-1:0] caddr, taddr;
   logic          cin, tin, cpu_wr, t_wr, same_w;

   assign cidx   = a >> OFS;
   assign tidx   = ta >> OFS;
   assign cin    = cidx < 32'(DEPTH);
   assign tin    = tidx < 32'(DEPTH);
   assign caddr  = cidx[AW-1:0];
   assign taddr  = tidx[AW-1:0];
   assign cpu_wr = ready & we & cin;
   assign t_wr   = ready & te & tin;
   assign same_w = (caddr == taddr);

   // Storage: no reset so the array maps onto block RAM.
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem_q[clr_addr] <= '0;
      end
      for (int unsigned i = 0; i < NB; i++) begin
         // A T lane is dropped only when the CPU writes that same lane of the
         // same word, so the two writes never collide on one byte.
         if (t_wr && tbe[i] && !(cpu_wr && same_w && be[i])) begin
            mem_q[taddr][i*8 +: 8] <= td[i*8 +: 8];
         end
         if (cpu_wr && be[i]) begin
            mem_q[caddr][i*8 +: 8] <= wd[i*8 +: 8];
         end
      end
   end

   // Read data as seen by each port; write-first merges this cycle's writes.
   logic [DATA_W-1:0] cpu_old, t_old, cpu_new, t_new, cpu_rdata, t_rdata;

   always_comb begin
      cpu_old = mem_q[caddr];
      t_old   = mem_q[taddr];
      cpu_new = cpu_old;
      t_new   = t_old;
      for (int unsigned i = 0; i < NB; i++) begin
         if (cpu_wr && be[i]) begin
            cpu_new[i*8 +: 8] = wd[i*8 +: 8];
         end else if (t_wr && same_w && tbe[i]) begin
            cpu_new[i*8 +: 8] = td[i*8 +: 8];
         end
         if (cpu_wr && same_w && be[i]) begin
            t_new[i*8 +: 8] = wd[i*8 +: 8];
         end else if (t_wr && tbe[i]) begin
            t_new[i*8 +: 8] = td[i*8 +: 8];
         end
      end
      cpu_rdata = '0;
      t_rdata   = '0;
      if (cin) begin
         cpu_rdata = (RD_MODE == WR_FIRST) ? cpu_new : cpu_old;
      end
      if (tin) begin
         t_rdata = (RD_MODE == WR_FIRST) ? t_new : t_old;
      end
   end

   logic [DATA_W-1:0] rd_q, rtd_q;
   logic              rvalid_q, trvalid_q, aerr_q, terr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_q      <= '0;
         rtd_q     <= '0;
         rvalid_q  <= 1'b0;
         trvalid_q <= 1'b0;
         aerr_q    <= 1'b0;
         terr_q    <= 1'b0;
      end else begin
         rvalid_q  <= ready & re;
         trvalid_q <= ready & tre;
         aerr_q    <= ready & (we | re) & ~cin;
         terr_q    <= ready & (te | tre) & ~tin;
         if (ready & re) begin
            rd_q <= cpu_rdata;
         end
         if (ready & tre) begin
            rtd_q <= t_rdata;
         end
      end
   end

   assign rd      = rd_q;
   assign rtd     = rtd_q;
   assign rvalid  = rvalid_q;
   assign trvalid = trvalid_q;
   assign aerr    = aerr_q;
   assign terr    = terr_q;

endmodule

// File: tb/tb_dual_port_dmem.sv
module tb_dual_port_dmem;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        we, te, re, tre;
   logic [31:0] a, ta, wd, td;
   logic [3:0]  be, tbe;

   // index 0: read-first instance, index 1: write-first instance
   logic [31:0] rd0, rd1, rtd0, rtd1;
   logic        rv0, rv1, trv0, trv1, ae0, ae1, terr0, terr1, rdy0, rdy1;

   always #5 clk = ~clk;

   dual_port_dmem #(
      .DATA_W         (32),
      .DEPTH          (256),
      .RD_MODE        (0),
      .CLEAR_ON_RESET (1)
   ) u_rf (
      .clk(clk), .rst_n(rst_n), .we(we), .te(te), .re(re), .tre(tre),
      .a(a), .ta(ta), .wd(wd), .td(td), .be(be), .tbe(tbe),
      .rd(rd0), .rtd(rtd0), .rvalid(rv0), .trvalid(trv0),
      .aerr(ae0), .terr(terr0), .ready(rdy0)
   );

   dual_port_dmem #(
      .DATA_W         (32),
      .DEPTH          (256),
      .RD_MODE        (1),
      .CLEAR_ON_RESET (1)
   ) u_wf (
      .clk(clk), .rst_n(rst_n), .we(we), .te(te), .re(re), .tre(tre),
      .a(a), .ta(ta), .wd(wd), .td(td), .be(be), .tbe(tbe),
      .rd(rd1), .rtd(rtd1), .rvalid(rv1), .trvalid(trv1),
      .aerr(ae1), .terr(terr1), .ready(rdy1)
   );

   int unsigned total = 0;
   int unsigned bad   = 0;

   logic [31:0] mem_m [256];
   logic [31:0] e_rd  [2];
   logic [31:0] e_rtd [2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_rd0"}, rd0, 32'h0);
      chk({tag, "_rd1"}, rd1, 32'h0);
      chk({tag, "_rtd0"}, rtd0, 32'h0);
      chk({tag, "_rtd1"}, rtd1, 32'h0);
      chk({tag, "_valids"}, {28'h0, rv0, rv1, trv0, trv1}, 32'h0);
      chk({tag, "_errs"}, {28'h0, ae0, ae1, terr0, terr1}, 32'h0);
      chk({tag, "_ready"}, {30'h0, rdy0, rdy1}, 32'h0);
   endtask

   task automatic clear_model();
      for (int i = 0; i < 256; i++) mem_m[i] = 32'h0;
      e_rd[0] = 32'h0; e_rd[1] = 32'h0; e_rtd[0] = 32'h0; e_rtd[1] = 32'h0;
   endtask

   // Counts rising edges from release until both instances report ready.
   task automatic wait_ready(input string tag);
      int n = 0;
      while (n < 2000) begin
         @(posedge clk); #1;
         n++;
         if (rdy0 && rdy1) break;
      end
      chk(tag, n, 256);
   endtask

   // Word contents after this cycle's writes: T lanes first, CPU lanes override.
   function automatic logic [31:0] after_writes(
      input int unsigned idx,
      input logic cw, input int unsigned cidx, input logic [31:0] wdv, input logic [3:0] bev,
      input logic tw, input int unsigned tidx, input logic [31:0] tdv, input logic [3:0] tbev);
      logic [31:0] w;
      w = mem_m[idx];
      for (int l = 0; l < 4; l++) begin
         if (tw && tidx == idx && tbev[l]) w[l*8 +: 8] = tdv[l*8 +: 8];
         if (cw && cidx == idx && bev[l])  w[l*8 +: 8] = wdv[l*8 +: 8];
      end
      return w;
   endfunction

   task automatic txn(
      input logic i_we, input logic i_re, input logic [31:0] i_a, input logic [31:0] i_wd,
      input logic [3:0] i_be,
      input logic i_te, input logic i_tre, input logic [31:0] i_ta, input logic [31:0] i_td,
      input logic [3:0] i_tbe);
      int unsigned cidx, tidx;
      logic        cin, tin, cw, tw;
      logic [31:0] oldc, oldt, newc, newt;
      cidx = i_a >> 2;
      tidx = i_ta >> 2;
      cin  = cidx < 256;
      tin  = tidx < 256;
      cw   = i_we && cin;
      tw   = i_te && tin;
      oldc = cin ? mem_m[cidx] : 32'h0;
      oldt = tin ? mem_m[tidx] : 32'h0;
      newc = cin ? after_writes(cidx, cw, cidx, i_wd, i_be, tw, tidx, i_td, i_tbe) : 32'h0;
      newt = tin ? after_writes(tidx, cw, cidx, i_wd, i_be, tw, tidx, i_td, i_tbe) : 32'h0;
      if (i_re)  begin e_rd[0]  = oldc; e_rd[1]  = newc; end
      if (i_tre) begin e_rtd[0] = oldt; e_rtd[1] = newt; end
      if (cw) mem_m[cidx] = newc;
      if (tw) mem_m[tidx] = newt;

      we = i_we; re = i_re; a = i_a; wd = i_wd; be = i_be;
      te = i_te; tre = i_tre; ta = i_ta; td = i_td; tbe = i_tbe;
      @(posedge clk); #1;
      we = 1'b0; re = 1'b0; te = 1'b0; tre = 1'b0;

      chk("rd_rdfirst", rd0, e_rd[0]);
      chk("rd_wrfirst", rd1, e_rd[1]);
      chk("rtd_rdfirst", rtd0, e_rtd[0]);
      chk("rtd_wrfirst", rtd1, e_rtd[1]);
      chk("rvalid", {30'h0, rv0, rv1}, {30'h0, i_re, i_re});
      chk("trvalid", {30'h0, trv0, trv1}, {30'h0, i_tre, i_tre});
      chk("aerr", {30'h0, ae0, ae1}, {30'h0, {2{(i_we | i_re) & ~cin}}});
      chk("terr", {30'h0, terr0, terr1}, {30'h0, {2{(i_te | i_tre) & ~tin}}});
   endtask

   function automatic logic [31:0] rand_addr();
      int unsigned r, idx;
      r = $urandom_range(0, 9);
      if (r < 7)       idx = r;
      else if (r == 7) idx = $urandom_range(0, 255);
      else             idx = 256 + $urandom_range(0, 3);
      return (idx << 2) | $urandom_range(0, 3);
   endfunction

   initial begin
      rst_n = 1'b1;
      we = 1'b0; te = 1'b0; re = 1'b0; tre = 1'b0;
      a = '0; ta = '0; wd = '0; td = '0; be = '0; tbe = '0;
      clear_model();

      // Power-up reset and clear timing
      #2 rst_n = 1'b0;
      #1 chk_reset_outputs("por");
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      wait_ready("init_cycles");

      // Cleared contents, including boundary index 255
      txn(0, 1, 32'h0, 0, 0,        0, 1, 32'd17 * 4, 0, 0);
      chk("clr_idx0", rd0, 32'h0);
      txn(0, 1, 32'd17 * 4, 0, 0,   0, 1, 32'd255 * 4, 0, 0);
      chk("clr_idx255", rtd1, 32'h0);

      // Full-word write, read with aligned and unaligned address
      txn(1, 0, 32'h40, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0);
      txn(0, 1, 32'h40, 0, 0,        0, 0, 0, 0, 0);
      chk("wr_rd_40", rd0, 32'hDEADBEEF);
      txn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("rd_hold", rd0, 32'hDEADBEEF);
      txn(0, 1, 32'h43, 0, 0,        0, 0, 0, 0, 0);
      chk("rd_43", rd1, 32'hDEADBEEF);

      // Last in-range word
      txn(1, 0, 32'h3FC, 32'hCAFEF00D, 4'hF, 0, 0, 0, 0, 0);
      txn(0, 0, 0, 0, 0,             0, 1, 32'h3FF, 0, 0);
      chk("idx255", rtd0, 32'hCAFEF00D);

      // Same-word write from both ports
      txn(1, 0, 32'h80, 32'h11111111, 4'h3, 1, 0, 32'h80, 32'h22222222, 4'h6);
      txn(0, 1, 32'h80, 0, 0,        0, 0, 0, 0, 0);
      chk("collide", rd0, 32'h00221111);

      // Read-first vs write-first on the T port
      txn(1, 0, 32'hC0, 32'hA5A5A5A5, 4'hF, 0, 0, 0, 0, 0);
      txn(1, 0, 32'hC0, 32'h5A5A5A5A, 4'hF, 0, 1, 32'hC0, 0, 0);
      chk("rdmode0", rtd0, 32'hA5A5A5A5);
      chk("rdmode1", rtd1, 32'h5A5A5A5A);

      // Out of range on both ports
      txn(0, 1, 32'h400, 0, 0,       0, 1, 32'h404, 0, 0);
      chk("oor_rd", rd0, 32'h0);
      chk("oor_aerr", {31'h0, ae0}, 32'h1);
      txn(1, 0, 32'h400, 32'hFFFFFFFF, 4'hF, 1, 0, 32'hFFFFFFFC, 32'hFFFFFFFF, 4'hF);
      chk("oor_aerr_drop", {31'h0, ae0}, 32'h1);
      txn(0, 1, 32'h0, 0, 0,         0, 0, 0, 0, 0);
      chk("oor_wr_idx0", rd0, 32'h0);

      // Randomized traffic against the model
      for (int k = 0; k < 400; k++) begin
         txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr(), $urandom(),
             4'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr(), $urandom(),
             4'($urandom_range(0, 15)));
      end

      // Make sure rd holds something nonzero, then reset mid-run
      txn(1, 0, 32'h10, 32'h87654321, 4'hF, 0, 0, 0, 0, 0);
      txn(0, 1, 32'h10, 0, 0, 0, 1, 32'h10, 0, 0);
      @(negedge clk) rst_n = 1'b0;
      #1 chk_reset_outputs("run_rst");
      clear_model();
      @(negedge clk) rst_n = 1'b1;

      // Reset again part-way through clearing
      repeat (100) @(posedge clk);
      #1 chk("ready_mid_init", {30'h0, rdy0, rdy1}, 32'h0);
      @(negedge clk) rst_n = 1'b0;
      #1 chk_reset_outputs("init_rst");
      @(negedge clk) rst_n = 1'b1;
      wait_ready("reinit_cycles");

      txn(0, 1, 32'h10, 0, 0, 0, 1, 32'd200 * 4, 0, 0);
      chk("recleared", rd0, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
